scu_dma_bus_arbiter: RTL and testbench
======================================

Name: scu_dma_bus_arbiter

Overview:
- Arbitrates the SCU external DMA bus between the three SCU DMA level channels (L0, L1, L2) and the SCU DSP DMA port (REQ/ACK/LAST/END).
- Sequences each burst: grant, per-transfer acknowledge, and an end-of-burst END pulse. The END pulse is long enough for the DSP falling-edge END detector.
- Sits between the DMA requesters and the A/B-bus interface inside the SCU.

Parameters:
- MAX_BURST, 8, transfers per grant before a higher-priority requester may preempt; 0 = never preempt.
- END_LEN, 4, CE-qualified cycles that END stays high; minimum 1.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- CE  in  1  clock enable; all state advances only when CE=1
- REQ  in  4  per-requester transfer request; bit0=L0, bit1=L1, bit2=L2, bit3=DSP
- LAST  in  4  requester's pending transfer is its last
- WE  in  4  requester's transfer direction (1 = write to bus)
- GNT  out  4  one-hot current bus owner
- ACK  out  4  one-hot per-transfer acknowledge, one CE cycle
- END  out  4  one-hot end-of-burst, held END_LEN CE cycles
- BUS_REQ  out  1  bus transfer request
- BUS_SEL  out  2  index of the owning requester
- BUS_WE  out  1  direction of the current transfer, equal to WE[owner]
- BUS_RDY  in  1  bus completed the current transfer (sampled when CE=1)
- BUSY  out  1  arbiter state is not IDLE

Behaviour:
- Reset (RST=1, any time, including mid-burst):
  - State goes to IDLE; burst counter and END counter clear.
  - GNT, ACK, END, BUS_REQ, BUS_SEL, BUS_WE, BUSY all = 0.
  - No ACK or END is emitted for an aborted burst.
- Priority: fixed, L0 > L1 > L2 > DSP.
- States: IDLE, XFER, HOLD, DONE.
- IDLE:
  - If any REQ bit is set, latch owner = highest-priority requester.
  - GNT[owner]=1, counter=0, go to XFER.
  - Grant is visible the cycle after REQ is sampled (one CE cycle latency).
- XFER:
  - BUS_REQ=1, BUS_SEL=owner, BUS_WE=WE[owner].
  - REQ dropping before BUS_RDY does not cancel the committed transfer.
  - When BUS_RDY=1: ACK[owner] pulses for exactly one CE cycle and the counter increments (saturates at 255). Then check, in priority order:
    - LAST[owner]=1 → DONE. LAST wins over preemption.
    - MAX_BURST≠0, counter reached MAX_BURST, and a higher-priority REQ is set → switch owner directly to that requester. Counter clears; no END for the preempted requester, which keeps its REQ and resumes later.
    - REQ[owner]=1 → stay in XFER.
    - Otherwise → HOLD.
  - BUS_REQ drops for at least the cycle in which ACK is high.
- HOLD (owner paused between transfers):
  - BUS_REQ=0; GNT is held.
  - If REQ[owner]=1 → XFER.
  - Else if a higher-priority REQ is set → switch owner (same rule as preemption).
- DONE:
  - BUS_REQ=0, END[owner]=1 for END_LEN CE cycles.
  - Then GNT and END clear → IDLE.
  - REQ seen while in DONE is arbitrated fresh from IDLE on the next CE cycle.
- CE=0: state, counters and outputs hold. ACK stays high if already high, but still spans only one CE-qualified cycle.
- LAST on a non-owner, or on an owner with REQ=0: ignored.
- GNT, ACK and END are always one-hot or zero.

Test Plan:
- DSP alone:
  - Stimulus: REQ=4'b1000, LAST on 3rd transfer, BUS_RDY one cycle after each BUS_REQ.
  - Response: GNT=4'b1000, three ACK[3] pulses, BUS_SEL=3, then END[3] high exactly 4 CE cycles, then BUSY=0.
- Priority at idle:
  - Stimulus: REQ=4'b1010 in the same cycle.
  - Response: GNT=4'b0010 (L1). DSP is granted only after END[1] completes.
- Preemption at MAX_BURST=8:
  - Stimulus: DSP bursts 20 transfers; L0 raises REQ at transfer 3.
  - Response: after the 8th ACK[3], GNT switches to 4'b0001 with no END[3]. DSP regains grant after END[0].
- LAST coinciding with the preemption point:
  - Stimulus: LAST[3]=1 on the 8th transfer while REQ[0]=1.
  - Response: DONE, END[3] pulses, then L0 is granted.
- Reset mid-transfer:
  - Stimulus: assert RST while BUS_REQ=1 and BUS_RDY is pending.
  - Response: all outputs 0 immediately, no ACK/END afterwards; after release, fresh arbitration from IDLE.
- CE gating:
  - Stimulus: CE=1 every 3rd clock, single DSP transfer.
  - Response: ACK high for exactly one CE cycle (3 clocks); END held 4 CE cycles (12 clocks).

Source files
------------

// File: rtl/scu_dma_bus_arbiter.sv
// SCU DMA bus arbiter.
// Fixed-priority ownership of the external DMA bus between the three level
// channels (L0 > L1 > L2) and the DSP DMA port, with per-transfer ACK,
// burst preemption after MAX_BURST transfers and a stretched END pulse.
module scu_dma_bus_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int END_LEN   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic [3:0] REQ,
  input  logic [3:0] LAST,
  input  logic [3:0] WE,
  output logic [3:0] GNT,
  output logic [3:0] ACK,
  output logic [3:0] END,
  output logic       BUS_REQ,
  output logic [1:0] BUS_SEL,
  output logic       BUS_WE,
  input  logic       BUS_RDY,
  output logic       BUSY
);

  // END must be held for at least one CE cycle, even if configured lower.
  localparam int END_LEN_C = (END_LEN < 1) ? 1 : END_LEN;
  localparam int EW = (END_LEN_C > 1) ? $clog2(END_LEN_C) : 1;
  localparam logic [EW-1:0] END_LAST = EW'(END_LEN_C - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    owner, owner_nxt;
  logic [7:0]    burst_cnt, burst_cnt_nxt;
  logic [EW-1:0] end_cnt, end_cnt_nxt;
  logic [3:0]    ack_q, ack_nxt;

  logic [3:0]    owner_mask;
  logic [3:0]    higher_req;
  logic [7:0]    cnt_inc;
  logic          cnt_at_limit;
  logic          ack_idle;

  // Index of the highest-priority set bit (bit 0 wins); 3 when only DSP or none.
  function automatic logic [1:0] pick(input logic [3:0] r);
    if (r[0])      pick = 2'd0;
    else if (r[1]) pick = 2'd1;
    else if (r[2]) pick = 2'd2;
    else           pick = 2'd3;
  endfunction

  // Helper terms: owner one-hot, requests that outrank the owner, saturating count.
  always_comb begin
    owner_mask   = 4'b0001 << owner;
    higher_req   = REQ & (owner_mask - 4'b0001);
    cnt_inc      = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
    cnt_at_limit = (MAX_BURST != 0) && (int'(cnt_inc) >= MAX_BURST);
    ack_idle     = (ack_q == 4'b0000);
  end

  // State register; everything advances only on CE-qualified edges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      owner     <= 2'd0;
      burst_cnt <= 8'd0;
      end_cnt   <= '0;
      ack_q     <= 4'b0000;
    end else if (CE) begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
      end_cnt   <= end_cnt_nxt;
      ack_q     <= ack_nxt;
    end
  end

  // Next-state logic: arbitration, transfer completion, preemption and END timing.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    end_cnt_nxt   = end_cnt;
    ack_nxt       = 4'b0000;
    case (state)
      IDLE: begin
        if (|REQ) begin
          owner_nxt     = pick(REQ);
          burst_cnt_nxt = 8'd0;
          state_nxt     = XFER;
        end
      end
      XFER: begin
        // The bus request is withdrawn while ACK is high, so BUS_RDY is only
        // meaningful once the previous acknowledge has retired.
        if (BUS_RDY && ack_idle) begin
          ack_nxt       = owner_mask;
          burst_cnt_nxt = cnt_inc;
          if (REQ[owner] && LAST[owner]) begin
            state_nxt   = DONE;
            end_cnt_nxt = '0;
          end else if (cnt_at_limit && (|higher_req)) begin
            owner_nxt     = pick(higher_req);
            burst_cnt_nxt = 8'd0;
          end else if (!REQ[owner]) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (REQ[owner]) begin
          state_nxt = XFER;
        end else if (|higher_req) begin
          owner_nxt     = pick(higher_req);
          burst_cnt_nxt = 8'd0;
          state_nxt     = XFER;
        end
      end
      DONE: begin
        if (end_cnt == END_LAST) begin
          state_nxt   = IDLE;
          end_cnt_nxt = '0;
        end else begin
          end_cnt_nxt = end_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state so reset clears them immediately.
  always_comb begin
    BUSY    = (state != IDLE);
    GNT     = BUSY ? owner_mask : 4'b0000;
    ACK     = ack_q;
    END     = (state == DONE) ? owner_mask : 4'b0000;
    BUS_REQ = (state == XFER) && ack_idle;
    BUS_SEL = BUS_REQ ? owner : 2'd0;
    BUS_WE  = BUS_REQ & WE[owner];
  end

endmodule

// File: tb/tb_scu_dma_bus_arbiter.sv
// Testbench for scu_dma_bus_arbiter: requester agents and a bus responder
// driven from a transfer-count model, with directed scenarios and a random mix.
`timescale 1ns/1ps
module tb_scu_dma_bus_arbiter;

  localparam int MAX_BURST = 8;
  localparam int END_LEN   = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE;
  logic [3:0] REQ, LAST, WE;
  logic [3:0] GNT, ACK, END;
  logic       BUS_REQ;
  logic [1:0] BUS_SEL;
  logic       BUS_WE;
  logic       BUS_RDY;
  logic       BUSY;

  scu_dma_bus_arbiter #(.MAX_BURST(MAX_BURST), .END_LEN(END_LEN)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .LAST(LAST), .WE(WE),
    .GNT(GNT), .ACK(ACK), .END(END), .BUS_REQ(BUS_REQ), .BUS_SEL(BUS_SEL),
    .BUS_WE(BUS_WE), .BUS_RDY(BUS_RDY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Requester model: transfers still owed per requester, plus observation logs.
  int remaining[4];
  int ack_cnt[4];
  int end_pulses[4];
  int end_ce[4];
  int total_req[4];
  int jobs[4];
  int gnt_q[$];
  int end_q[$];
  int preempt_q[$];
  int acks_in_grant;
  int rdy_pct;
  int viol;
  int idle_err;
  logic [3:0] ack_prev, gnt_prev, end_prev;
  logic       busy_prev;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit all_idle();
    return (remaining[0] == 0) && (remaining[1] == 0) && (remaining[2] == 0) &&
           (remaining[3] == 0) && !BUSY;
  endfunction

  // Grant / END order encoded as decimal digits (index+1), oldest first.
  function automatic int gnt_code();
    int c = 0;
    foreach (gnt_q[k]) c = c * 10 + gnt_q[k] + 1;
    return c;
  endfunction

  function automatic int end_code();
    int c = 0;
    foreach (end_q[k]) c = c * 10 + end_q[k] + 1;
    return c;
  endfunction

  task automatic clear_log();
    for (int i = 0; i < 4; i++) begin
      remaining[i] = 0; ack_cnt[i] = 0; end_pulses[i] = 0;
      end_ce[i] = 0; total_req[i] = 0; jobs[i] = 0;
    end
    gnt_q.delete(); end_q.delete(); preempt_q.delete();
    acks_in_grant = 0; viol = 0; idle_err = 0;
    ack_prev = 4'b0; gnt_prev = 4'b0; end_prev = 4'b0; busy_prev = 1'b0;
  endtask

  task automatic cycle();
    @(negedge CLK);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      REQ[i]  = (remaining[i] > 0);
      LAST[i] = (remaining[i] == 1);
    end
  endtask

  // Observe the outputs after an edge, update the model, and drive new inputs.
  task automatic agent_update();
    logic [3:0] new_ack, new_end;
    new_ack = ACK & ~ack_prev;
    new_end = END & ~end_prev;
    for (int i = 0; i < 4; i++) begin
      if (new_ack[i]) begin
        ack_cnt[i]++;
        if (remaining[i] > 0) remaining[i]--;
        acks_in_grant++;
      end
      if (new_end[i]) begin
        end_pulses[i]++;
        end_q.push_back(i);
      end
      if (END[i] && CE) end_ce[i]++;
    end
    if (((GNT & (GNT - 4'd1)) != 0) || ((ACK & (ACK - 4'd1)) != 0) ||
        ((END & (END - 4'd1)) != 0)) viol++;
    if (BUS_REQ && ((ACK != 0) || (GNT != (4'b0001 << BUS_SEL)) || (BUS_WE != WE[BUS_SEL])))
      viol++;
    if (!busy_prev && BUSY && ((lowest(REQ) < 0) || (GNT != (4'b0001 << lowest(REQ)))))
      idle_err++;
    if (GNT != gnt_prev) begin
      if ((GNT != 0) && (gnt_prev != 0)) preempt_q.push_back(acks_in_grant);
      if (GNT != 0) gnt_q.push_back(lowest(GNT));
      acks_in_grant = 0;
    end
    ack_prev  = ACK;
    end_prev  = END;
    gnt_prev  = GNT;
    busy_prev = BUSY;
    drive_reqs();
    BUS_RDY = BUS_REQ && ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic run_until_idle(input int limit, output bit timed_out);
    int n;
    for (n = 0; n < limit && !all_idle(); n++) begin
      cycle();
      agent_update();
    end
    timed_out = !all_idle();
  endtask

  task automatic reset_dut();
    RST = 1'b1; CE = 1'b1; REQ = 4'b0; LAST = 4'b0; WE = 4'b0; BUS_RDY = 1'b0;
    rdy_pct = 100;
    clear_log();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'b1; REQ = 4'hF; LAST = 4'h0; WE = 4'hF; BUS_RDY = 1'b1;
    repeat (3) cycle();
    compared++;
    if ({GNT, ACK, END} !== 12'h000) begin
      mismatched++;
      $display("[TB] FAIL reset_vectors: got GNT/ACK/END=%03h, expected 000", {GNT, ACK, END});
    end
    compared++;
    if ({BUS_REQ, BUS_SEL, BUS_WE, BUSY} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_bus: got %b, expected 00000", {BUS_REQ, BUS_SEL, BUS_WE, BUSY});
    end
  endtask

  task automatic test_dsp_alone();
    int  n;
    bit  to;
    logic we_bit;
    reset_dut();
    we_bit = 1'($urandom_range(0, 1));
    WE = {we_bit, 3'b000};
    remaining[3] = 3;
    drive_reqs();
    cycle();
    compared++;
    if (GNT !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL dsp_grant_latency: got %b, expected 1000", GNT);
    end
    agent_update();
    for (n = 0; n < 200 && !all_idle(); n++) begin
      cycle();
      if (BUS_REQ) begin
        compared++;
        if ((BUS_SEL !== 2'd3) || (BUS_WE !== we_bit)) begin
          mismatched++;
          $display("[TB] FAIL dsp_bus_sel: got sel=%0d we=%b, expected sel=3 we=%b", BUS_SEL, BUS_WE, we_bit);
        end
      end
      agent_update();
    end
    to = !all_idle();
    compared++;
    if (to) begin mismatched++; $display("[TB] FAIL dsp_timeout: got busy, expected idle"); end
    compared++;
    if (ack_cnt[3] != 3) begin mismatched++; $display("[TB] FAIL dsp_acks: got %0d, expected 3", ack_cnt[3]); end
    compared++;
    if (end_ce[3] != END_LEN || end_pulses[3] != 1) begin
      mismatched++;
      $display("[TB] FAIL dsp_end_len: got %0d cycles in %0d pulses, expected %0d in 1", end_ce[3], end_pulses[3], END_LEN);
    end
    compared++;
    if (gnt_code() != 4 || viol != 0) begin
      mismatched++;
      $display("[TB] FAIL dsp_grant_seq: got code %0d viol %0d, expected 4 and 0", gnt_code(), viol);
    end
  endtask

  task automatic test_priority_idle();
    bit to;
    reset_dut();
    remaining[1] = 2;
    remaining[3] = 2;
    drive_reqs();
    run_until_idle(300, to);
    compared++;
    if (to) begin mismatched++; $display("[TB] FAIL prio_timeout: got busy, expected idle"); end
    compared++;
    if (gnt_code() != 24 || end_code() != 24) begin
      mismatched++;
      $display("[TB] FAIL prio_order: got grants %0d ends %0d, expected 24 and 24", gnt_code(), end_code());
    end
    compared++;
    if (ack_cnt[1] != 2 || ack_cnt[3] != 2 || idle_err != 0) begin
      mismatched++;
      $display("[TB] FAIL prio_acks: got L1=%0d DSP=%0d idle_err=%0d, expected 2 2 0", ack_cnt[1], ack_cnt[3], idle_err);
    end
  endtask

  task automatic test_preemption();
    int n;
    bit inj;
    reset_dut();
    remaining[3] = 20;
    drive_reqs();
    inj = 1'b0;
    for (n = 0; n < 1000 && !(inj && all_idle()); n++) begin
      cycle();
      agent_update();
      if (!inj && ack_cnt[3] == 3) begin
        remaining[0] = 4;
        inj = 1'b1;
        drive_reqs();
      end
    end
    compared++;
    if (!all_idle()) begin mismatched++; $display("[TB] FAIL preempt_timeout: got busy, expected idle"); end
    compared++;
    if (gnt_code() != 414 || end_code() != 14) begin
      mismatched++;
      $display("[TB] FAIL preempt_order: got grants %0d ends %0d, expected 414 and 14", gnt_code(), end_code());
    end
    compared++;
    if (preempt_q.size() != 1 || preempt_q[0] != MAX_BURST) begin
      mismatched++;
      $display("[TB] FAIL preempt_point: got %0d switches, first after %0d acks, expected 1 after %0d",
               preempt_q.size(), (preempt_q.size() > 0) ? preempt_q[0] : -1, MAX_BURST);
    end
    compared++;
    if (ack_cnt[3] != 20 || ack_cnt[0] != 4) begin
      mismatched++;
      $display("[TB] FAIL preempt_acks: got DSP=%0d L0=%0d, expected 20 4", ack_cnt[3], ack_cnt[0]);
    end
  endtask

  task automatic test_last_at_preempt();
    int n;
    bit inj;
    reset_dut();
    remaining[3] = MAX_BURST;
    drive_reqs();
    inj = 1'b0;
    for (n = 0; n < 1000 && !(inj && all_idle()); n++) begin
      cycle();
      agent_update();
      if (!inj && ack_cnt[3] == 2) begin
        remaining[0] = 3;
        inj = 1'b1;
        drive_reqs();
      end
    end
    compared++;
    if (!all_idle()) begin mismatched++; $display("[TB] FAIL lastpre_timeout: got busy, expected idle"); end
    compared++;
    if (gnt_code() != 41 || end_code() != 41 || preempt_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL lastpre_order: got grants %0d ends %0d switches %0d, expected 41 41 0",
               gnt_code(), end_code(), preempt_q.size());
    end
    compared++;
    if (ack_cnt[3] != MAX_BURST || ack_cnt[0] != 3 || end_ce[3] != END_LEN) begin
      mismatched++;
      $display("[TB] FAIL lastpre_acks: got DSP=%0d L0=%0d endlen=%0d, expected %0d 3 %0d",
               ack_cnt[3], ack_cnt[0], end_ce[3], MAX_BURST, END_LEN);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int n;
    bit to;
    reset_dut();
    rdy_pct = 0;
    remaining[3] = 5;
    drive_reqs();
    for (n = 0; n < 20 && !BUS_REQ; n++) begin
      cycle();
      agent_update();
    end
    compared++;
    if (!BUS_REQ) begin mismatched++; $display("[TB] FAIL rst_mid_busreq: got 0, expected 1"); end
    BUS_RDY = 1'b1;
    #2 RST = 1'b1;
    #1;
    compared++;
    if ({GNT, ACK, END, BUS_REQ, BUS_SEL, BUS_WE, BUSY} !== 17'h0) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_outputs: got %h, expected 0", {GNT, ACK, END, BUS_REQ, BUS_SEL, BUS_WE, BUSY});
    end
    rdy_pct = 100;
    for (int k = 0; k < 3; k++) begin
      cycle();
      compared++;
      if ({ACK, END, GNT} !== 12'h000) begin
        mismatched++;
        $display("[TB] FAIL rst_mid_hold: got ACK/END/GNT=%03h, expected 000", {ACK, END, GNT});
      end
      agent_update();
    end
    RST = 1'b0;
    cycle();
    compared++;
    if (GNT !== 4'b1000) begin mismatched++; $display("[TB] FAIL rst_mid_regrant: got %b, expected 1000", GNT); end
    agent_update();
    run_until_idle(300, to);
    compared++;
    if (to || ack_cnt[3] != 5 || end_pulses[3] != 1 || end_q.size() != 1) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_after: got acks=%0d ends=%0d timeout=%0d, expected 5 1 0", ack_cnt[3], end_q.size(), to);
    end
  endtask

  task automatic test_ce_gating();
    int n, ph, ack_clk, end_clk;
    reset_dut();
    remaining[3] = 1;
    drive_reqs();
    ph = 0; ack_clk = 0; end_clk = 0;
    for (n = 0; n < 300 && !all_idle(); n++) begin
      cycle();
      if (ACK[3]) ack_clk++;
      if (END[3]) end_clk++;
      agent_update();
      ph++;
      CE = (ph % 3 == 0);
    end
    CE = 1'b1;
    compared++;
    if (!all_idle()) begin mismatched++; $display("[TB] FAIL ce_timeout: got busy, expected idle"); end
    compared++;
    if (ack_clk != 3 || ack_cnt[3] != 1) begin
      mismatched++;
      $display("[TB] FAIL ce_ack_width: got %0d clocks in %0d pulses, expected 3 in 1", ack_clk, ack_cnt[3]);
    end
    compared++;
    if (end_clk != 3 * END_LEN || end_ce[3] != END_LEN) begin
      mismatched++;
      $display("[TB] FAIL ce_end_width: got %0d clocks / %0d CE cycles, expected %0d / %0d",
               end_clk, end_ce[3], 3 * END_LEN, END_LEN);
    end
  endtask

  task automatic test_random();
    int n, a;
    logic [3:0] new_ack, hi, exp_gnt, exp_end;
    bit drain;
    reset_dut();
    rdy_pct = 60;
    drain = 1'b0;
    for (n = 0; n < 20000; n++) begin
      if (n >= 3000) drain = 1'b1;
      if (drain && all_idle()) break;
      cycle();
      new_ack = ACK & ~ack_prev;
      if (new_ack != 0) begin
        a = lowest(new_ack);
        hi = REQ & ((4'b0001 << a) - 4'b0001);
        exp_end = 4'b0;
        if (REQ[a] && LAST[a]) begin
          exp_gnt = 4'b0001 << a;
          exp_end = 4'b0001 << a;
        end else if ((acks_in_grant + 1 >= MAX_BURST) && (hi != 0)) begin
          exp_gnt = 4'b0001 << lowest(hi);
        end else begin
          exp_gnt = 4'b0001 << a;
        end
        compared++;
        if (GNT !== exp_gnt || END !== exp_end) begin
          mismatched++;
          $display("[TB] FAIL rand_after_ack: got GNT=%b END=%b, expected GNT=%b END=%b", GNT, END, exp_gnt, exp_end);
        end
      end
      agent_update();
      if (!drain) begin
        for (int i = 0; i < 4; i++) begin
          if (remaining[i] == 0 && $urandom_range(0, 63) == 0) begin
            remaining[i] = $urandom_range(1, 20);
            total_req[i] += remaining[i];
            jobs[i]++;
            WE[i] = 1'($urandom_range(0, 1));
          end
        end
        drive_reqs();
      end
      CE = ($urandom_range(0, 3) != 0);
    end
    CE = 1'b1;
    compared++;
    if (!all_idle()) begin mismatched++; $display("[TB] FAIL rand_timeout: got busy, expected idle"); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (ack_cnt[i] != total_req[i] || end_pulses[i] != jobs[i] || end_ce[i] != jobs[i] * END_LEN) begin
        mismatched++;
        $display("[TB] FAIL rand_totals[%0d]: got acks=%0d ends=%0d endcyc=%0d, expected %0d %0d %0d",
                 i, ack_cnt[i], end_pulses[i], end_ce[i], total_req[i], jobs[i], jobs[i] * END_LEN);
      end
    end
    compared++;
    if (viol != 0 || idle_err != 0) begin
      mismatched++;
      $display("[TB] FAIL rand_rules: got viol=%0d idle_err=%0d, expected 0 0", viol, idle_err);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_dsp_alone();
    test_priority_idle();
    test_preemption();
    test_last_at_preempt();
    test_reset_mid_transfer();
    test_ce_gating();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
